// File: rtl/packet_buffer_read_arbiter.sv
// packet_buffer_read_arbiter: round-robin, lockable sharing of one RAM read port between two readers
module packet_buffer_read_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_lock,
    output logic                  a_gnt,
    output logic                  a_ready,
    output logic [DATA_WIDTH-1:0] a_out,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_lock,
    output logic                  b_gnt,
    output logic                  b_ready,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic                  ram_read_ready,
    input  logic [DATA_WIDTH-1:0] ram_read_out,
    output logic                  busy
);
    logic                   last, lock_valid, lock_owner, issue_tag, lock_held;
    logic [RAM_LATENCY-1:0] tag_valid, tag_id;
    // A lock whose owner has dropped its lock input is released in the same cycle
    assign lock_held = lock_valid & (lock_owner ? b_lock : a_lock);
    always_comb begin
        a_gnt = lock_held ? ~lock_owner & a_req : a_req & (~b_req | last);
        b_gnt = lock_held ? lock_owner & b_req : b_req & (~a_req | ~last);
    end
    assign a_ready = ram_read_ready & tag_valid[RAM_LATENCY-1] & ~tag_id[RAM_LATENCY-1];
    assign b_ready = ram_read_ready & tag_valid[RAM_LATENCY-1] & tag_id[RAM_LATENCY-1];
    assign a_out   = ram_read_out;
    assign b_out   = ram_read_out;
    assign busy    = ram_read_req | (|tag_valid);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last          <= 1'b1;
            lock_valid    <= 1'b0;
            lock_owner    <= 1'b0;
            ram_read_req  <= 1'b0;
            ram_read_addr <= '0;
            issue_tag     <= 1'b0;
            tag_valid     <= '0;
            tag_id        <= '0;
        end else begin
            if (a_gnt | b_gnt) begin
                last          <= b_gnt;
                lock_owner    <= b_gnt;
                ram_read_addr <= b_gnt ? b_addr : a_addr;
                issue_tag     <= b_gnt;
            end
            lock_valid   <= lock_held | (a_gnt & a_lock) | (b_gnt & b_lock);
            ram_read_req <= a_gnt | b_gnt;
            tag_valid    <= RAM_LATENCY'({tag_valid, ram_read_req});
            tag_id       <= RAM_LATENCY'({tag_id, issue_tag});
        end
    end
endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// tb_packet_buffer_read_arbiter: checks three latency variants against a cycle-history reference model
module tb_packet_buffer_read_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_lock = 1'b0, b_req = 1'b0, b_lock = 1'b0, spur = 1'b0;
    logic [10:0] a_addr = '0, b_addr = '0;
    logic        a_gnt_w [3], b_gnt_w [3], a_rdy_w [3], b_rdy_w [3], rrq_w [3], busy_w [3], rrdy_w [3];
    logic [10:0] raddr_w [3];
    logic [7:0]  a_out_w [3], b_out_w [3], rout_w [3];
    logic [7:0]  mem [2048];
    int          ntests = 0, nfail = 0, cyc = 64;
    int          m_last = 1, m_lock = -1;
    logic [10:0] m_addr = '0;
    bit          gh [32];
    bit          gw [32];
    logic [10:0] gaddr [32];
    bit          lg_a, lg_b;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic        pv [L];
        logic [10:0] pa [L];
        always @(posedge clk) begin
            pv[0] <= rrq_w[g];
            pa[0] <= raddr_w[g];
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
        assign rrdy_w[g] = pv[L-1] | spur;
        assign rout_w[g] = pv[L-1] ? mem[pa[L-1]] : 8'hEE;
        packet_buffer_read_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .RAM_LATENCY(L)) dut (
            .clk(clk), .reset(reset),
            .a_req(a_req), .a_addr(a_addr), .a_lock(a_lock), .a_gnt(a_gnt_w[g]), .a_ready(a_rdy_w[g]), .a_out(a_out_w[g]),
            .b_req(b_req), .b_addr(b_addr), .b_lock(b_lock), .b_gnt(b_gnt_w[g]), .b_ready(b_rdy_w[g]), .b_out(b_out_w[g]),
            .ram_read_req(rrq_w[g]), .ram_read_addr(raddr_w[g]), .ram_read_ready(rrdy_w[g]),
            .ram_read_out(rout_w[g]), .busy(busy_w[g])
        );
    end

    function automatic int lat(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: derive the expected grant from the arbitration rules, compare every
    // instance's outputs mid-cycle, then advance the model and the clock.
    task automatic step();
        bit held, ga, gb, er, eb;
        int k;
        if (reset) begin
            m_last = 1;
            m_lock = -1;
            m_addr = '0;
            for (int i = 0; i < 32; i++) gh[i] = 0;
        end
        held = (m_lock >= 0) && ((m_lock == 0) ? a_lock : b_lock);
        if (!held) m_lock = -1;
        if (reset) begin
            ga = 0; gb = 0;
        end else if (held) begin
            ga = (m_lock == 0) && a_req;
            gb = (m_lock == 1) && b_req;
        end else if (a_req && b_req) begin
            ga = (m_last == 1);
            gb = (m_last == 0);
        end else begin
            ga = a_req;
            gb = b_req;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            k  = (cyc - 1 - lat(i)) % 32;
            er = gh[k];
            eb = 0;
            for (int j = 1; j <= lat(i) + 1; j++) eb |= gh[(cyc - j) % 32];
            chk($sformatf("a_gnt[L%0d]", lat(i)), 32'(a_gnt_w[i]), 32'(ga));
            chk($sformatf("b_gnt[L%0d]", lat(i)), 32'(b_gnt_w[i]), 32'(gb));
            chk($sformatf("a_ready[L%0d]", lat(i)), 32'(a_rdy_w[i]), 32'(er && !gw[k]));
            chk($sformatf("b_ready[L%0d]", lat(i)), 32'(b_rdy_w[i]), 32'(er && gw[k]));
            chk($sformatf("ram_read_req[L%0d]", lat(i)), 32'(rrq_w[i]), 32'(gh[(cyc - 1) % 32]));
            chk($sformatf("ram_read_addr[L%0d]", lat(i)), 32'(raddr_w[i]), 32'(m_addr));
            chk($sformatf("busy[L%0d]", lat(i)), 32'(busy_w[i]), 32'(eb));
            if (er && !gw[k]) chk($sformatf("a_out[L%0d]", lat(i)), 32'(a_out_w[i]), 32'(mem[gaddr[k]]));
            if (er && gw[k])  chk($sformatf("b_out[L%0d]", lat(i)), 32'(b_out_w[i]), 32'(mem[gaddr[k]]));
        end
        gh[cyc % 32]    = ga | gb;
        gw[cyc % 32]    = gb;
        gaddr[cyc % 32] = gb ? b_addr : a_addr;
        if (ga | gb) begin
            m_addr = gb ? b_addr : a_addr;
            m_last = gb ? 1 : 0;
            if ((ga && a_lock) || (gb && b_lock)) m_lock = gb ? 1 : 0;
        end
        lg_a = ga;
        lg_b = gb;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        repeat (5) step();
        reset = 1'b0;
        // single A read at 0x005
        a_req = 1'b1; a_addr = 11'h005;
        step();
        a_req = 1'b0;
        repeat (6) step();
        // both requesters streaming: strict alternation
        a_req = 1'b1; b_req = 1'b1; a_addr = 11'h010; b_addr = 11'h100;
        repeat (10) begin
            step();
            if (lg_a) a_addr++;
            if (lg_b) b_addr++;
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (7) step();
        // B locks for four grants while A waits, then releases
        b_lock = 1'b1; b_req = 1'b1; b_addr = 11'h200;
        step();
        a_req = 1'b1; a_addr = 11'h030;
        repeat (3) begin
            b_addr++;
            step();
        end
        b_lock = 1'b0; b_req = 1'b0;
        step();
        a_req = 1'b0;
        repeat (7) step();
        // spurious ram_read_ready with nothing pending
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        // reset one cycle after an issue while the RAM is still answering
        a_req = 1'b1; a_addr = 11'h077;
        step();
        a_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        a_req = 1'b1; a_addr = 11'h078;
        step();
        a_req = 1'b0;
        repeat (7) step();
        // randomized traffic respecting hold-until-grant
        repeat (400) begin
            if (!a_req || lg_a) begin
                a_req  = $urandom_range(0, 2) != 0;
                a_addr = 11'($urandom);
            end
            if (!b_req || lg_b) begin
                b_req  = $urandom_range(0, 2) != 0;
                b_addr = 11'($urandom);
            end
            if ($urandom_range(0, 7) == 0) a_lock = ~a_lock;
            if ($urandom_range(0, 7) == 0) b_lock = ~b_lock;
            spur = $urandom_range(0, 9) == 0;
            step();
        end
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0; spur = 1'b0;
        repeat (8) step();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
